// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem read, one/two-word instruction assembly into IF/ID.
// Optional interrupt entry is enabled by defining FETCH_INT_EN.
module fetch_stage #(
  parameter int                N          = 16,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(16'h0020)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [N-1:0]      imem_data,
  output logic [N-1:0]      instr_out,
  output logic [N-1:0]      imm_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out
`ifdef FETCH_INT_EN
  ,
  input  logic              irq
`endif
);

  typedef enum logic {FETCH_OP, FETCH_IMM} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc;
  logic [N-1:0]      op_hold, op_hold_n;
  logic [ADDR_W-1:0] op_pc, op_pc_n;
  logic [N-1:0]      instr_n, imm_n;
  logic [ADDR_W-1:0] pc_out_n;
  logic              valid_n;
  logic              int_take;

  assign imem_addr = pc;
  assign pc_inc    = pc + ADDR_W'(1);

`ifdef FETCH_INT_EN
  logic pend, pend_n;

  // Only interrupt on an instruction boundary, and never against a redirect or stall.
  assign int_take = pend && (state == FETCH_OP) && !stall && !redirect;
  assign pend_n   = int_take ? 1'b0 : (pend | irq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= 1'b0;
    else        pend <= pend_n;
  end
`else
  assign int_take = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    op_hold_n = op_hold;
    op_pc_n   = op_pc;
    instr_n   = instr_out;
    imm_n     = imm_out;
    pc_out_n  = pc_out;
    valid_n   = valid_out;
    if (redirect) begin
      pc_n    = redirect_pc;
      state_n = FETCH_OP;
      valid_n = 1'b0;
    end else if (!stall) begin
      if (state == FETCH_IMM) begin
        instr_n  = op_hold;
        imm_n    = imem_data;
        pc_out_n = op_pc;
        valid_n  = 1'b1;
        pc_n     = pc_inc;
        state_n  = FETCH_OP;
      end else if (int_take) begin
        // INT pseudo-op carries the un-incremented PC as return address.
        instr_n  = '1;
        imm_n    = '0;
        pc_out_n = pc;
        valid_n  = 1'b1;
        pc_n     = IRQ_VECTOR;
      end else if (imem_data[N-1]) begin
        op_hold_n = imem_data;
        op_pc_n   = pc;
        valid_n   = 1'b0;
        pc_n      = pc_inc;
        state_n   = FETCH_IMM;
      end else begin
        instr_n  = imem_data;
        imm_n    = '0;
        pc_out_n = pc;
        valid_n  = 1'b1;
        pc_n     = pc_inc;
      end
    end
  end

  // IF/ID boundary: everything below is registered toward decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH_OP;
      pc        <= RESET_PC;
      op_hold   <= '0;
      op_pc     <= '0;
      instr_out <= '0;
      imm_out   <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      op_hold   <= op_hold_n;
      op_pc     <= op_pc_n;
      instr_out <= instr_n;
      imm_out   <= imm_n;
      pc_out    <= pc_out_n;
      valid_out <= valid_n;
    end
  end

endmodule
